// File: rtl/switch_pkg.sv
// Shared switch definitions: default buffer geometry and the flit word type
// (32-bit payload plus tag bit).
package switch_pkg;

    localparam int SW_WIDTH = 33;
    localparam int SW_DEPTH = 8;
    localparam int SW_N_CH  = 4;

    typedef struct packed {
        logic        tag;
        logic [31:0] payload;
    } flit_t;

    // Channel index width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voq_ch_ctrl.sv
// Per-channel FIFO bookkeeping for voq_buffer: write/read pointers, occupancy
// and registered empty/full flags. push/pop arrive already qualified.
module voq_ch_ctrl #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    logic [CNT_W-1:0] count_nxt;

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: rtl/voq_buffer.sv
// Virtual-output-queue buffer: N_CH FIFOs sharing one storage array addressed
// {ch, ptr}, one write port, one registered read port, sticky error flags.
// Optional feature macro VOQ_ALMOST_FULL_EN adds AFULL_THRESH and almost_full.
module voq_buffer
    import switch_pkg::*;
#(
    parameter int WIDTH = SW_WIDTH,
    parameter int DEPTH = SW_DEPTH,
    parameter int N_CH  = SW_N_CH,
`ifdef VOQ_ALMOST_FULL_EN
    parameter int AFULL_THRESH = DEPTH - 2,
`endif
    localparam int CH_W  = ch_width(N_CH),
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_ch,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [CH_W-1:0]       rd_ch,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic [CH_W-1:0]       rd_ch_q,
    output logic [N_CH-1:0]       empty,
    output logic [N_CH-1:0]       full,
    output logic [N_CH*CNT_W-1:0] count,
`ifdef VOQ_ALMOST_FULL_EN
    output logic [N_CH-1:0]       almost_full,
`endif
    output logic                  ovf_err,
    output logic                  udf_err,
    input  logic                  err_clr
);

    // Channel-indexed views padded to the full select range, so an index of a
    // non-existent channel reads as "absent, empty and full" and is rejected.
    localparam int NCH_P = 1 << CH_W;

    logic [NCH_P-1:0] ch_ok;
    logic [NCH_P-1:0] empty_x;
    logic [NCH_P-1:0] full_x;
    logic [PTR_W-1:0] wr_ptr_x [NCH_P];
    logic [PTR_W-1:0] rd_ptr_x [NCH_P];
    logic [CNT_W-1:0] cnt_ch   [N_CH];
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  pop;

    logic                  rd_acc;
    logic                  wr_acc;
    logic [CH_W+PTR_W-1:0] wr_addr;
    logic [CH_W+PTR_W-1:0] rd_addr;
    logic [WIDTH-1:0]      mem [N_CH*DEPTH];

    // No fall-through: a read needs an entry already present before the edge.
    // A full channel still accepts a write when the same channel is popped.
    assign rd_acc  = rd_en && ch_ok[rd_ch] && !empty_x[rd_ch];
    assign wr_acc  = wr_en && ch_ok[wr_ch] &&
                     (!full_x[wr_ch] || (rd_acc && (rd_ch == wr_ch)));
    assign wr_addr = {wr_ch, wr_ptr_x[wr_ch]};
    assign rd_addr = {rd_ch, rd_ptr_x[rd_ch]};

    for (genvar g = 0; g < NCH_P; g++) begin : g_ch
        if (g < N_CH) begin : g_real
            assign push[g] = wr_acc && (wr_ch == CH_W'(g));
            assign pop[g]  = rd_acc && (rd_ch == CH_W'(g));

            voq_ch_ctrl #(
                .DEPTH (DEPTH),
                .PTR_W (PTR_W),
                .CNT_W (CNT_W)
            ) u_ctrl (
                .clk    (clk),
                .rst    (rst),
                .push   (push[g]),
                .pop    (pop[g]),
                .wr_ptr (wr_ptr_x[g]),
                .rd_ptr (rd_ptr_x[g]),
                .count  (cnt_ch[g]),
                .empty  (empty[g]),
                .full   (full[g])
            );

            assign ch_ok[g]   = 1'b1;
            assign empty_x[g] = empty[g];
            assign full_x[g]  = full[g];
            assign count[g*CNT_W +: CNT_W] = cnt_ch[g];

`ifdef VOQ_ALMOST_FULL_EN
            logic [CNT_W-1:0] cnt_nxt;

            // Mirror of the channel's next occupancy for the registered flag.
            always_comb begin
                cnt_nxt = cnt_ch[g];
                if (push[g] && !pop[g])
                    cnt_nxt = cnt_ch[g] + CNT_W'(1);
                else if (pop[g] && !push[g])
                    cnt_nxt = cnt_ch[g] - CNT_W'(1);
            end

            // Almost-full tracks the occupancy from the same edge as count.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    almost_full[g] <= 1'b0;
                else
                    almost_full[g] <= (cnt_nxt >= CNT_W'(AFULL_THRESH));
            end
`endif
        end else begin : g_pad
            assign ch_ok[g]    = 1'b0;
            assign empty_x[g]  = 1'b1;
            assign full_x[g]   = 1'b1;
            assign wr_ptr_x[g] = '0;
            assign rd_ptr_x[g] = '0;
        end
    end

    // Shared storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_addr] <= wr_data;
    end

    // Read register: loads only on an accepted read, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_ch_q  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_addr];
                rd_ch_q <= rd_ch;
            end
        end
    end

    // Sticky errors; a clear wins over a new error in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_en && !wr_acc)
                ovf_err <= 1'b1;
            if (rd_en && !rd_acc)
                udf_err <= 1'b1;
        end
    end

endmodule

// File: doc/voq_buffer.md
# voq_buffer

Parametrised virtual-output-queue buffer for the 4x4 switch: N_CH independent FIFOs sharing one storage array, one write port and one read port, each steered by a channel index. It sits between an input port's receive logic and the crossbar arbiter, replacing the single-queue-per-port arrangement so that a blocked output does not stall traffic for the other outputs.

## Interface
Parameters:
- WIDTH, 33: word width (32-bit payload plus tag bit).
- DEPTH, 8: entries per channel; a power of two, at least 2.
- N_CH, 4: number of channels (output ports).
- AFULL_THRESH, DEPTH-2: almost-full level. Present only with VOQ_ALMOST_FULL_EN.

Derived widths: CH_W = $clog2(N_CH) (minimum 1), PTR_W = $clog2(DEPTH), CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- wr_en  in  1  write request.
- wr_ch  in  CH_W  target channel.
- wr_data  in  WIDTH  write word.
- rd_en  in  1  read request.
- rd_ch  in  CH_W  source channel.
- rd_data  out  WIDTH  registered read word.
- rd_valid  out  1  rd_data updated this cycle.
- rd_ch_q  out  CH_W  channel that produced rd_data.
- empty  out  N_CH  per-channel empty flag.
- full  out  N_CH  per-channel full flag.
- count  out  N_CH*CNT_W  per-channel occupancy; channel i occupies bits [i*CNT_W +: CNT_W].
- almost_full  out  N_CH  count >= AFULL_THRESH. Present only with VOQ_ALMOST_FULL_EN.
- ovf_err  out  1  sticky: a write was dropped.
- udf_err  out  1  sticky: a read was rejected.
- err_clr  in  1  clears both sticky errors.

## Operation
- Reset, asynchronous assert: all pointers and counts go to 0. empty = all 1s. full, almost_full, rd_data, rd_valid, rd_ch_q, ovf_err and udf_err all go to 0. Memory contents are not reset.
- Write: accepted when wr_en=1, wr_ch < N_CH, and the channel is not full, or is full but a read of the same channel is accepted in the same cycle. The word is stored at that channel's wr_ptr. wr_ptr increments mod DEPTH.
- Dropped write: the write is otherwise dropped and ovf_err is set. A write with wr_ch >= N_CH is dropped with ovf_err set.
- Read: accepted when rd_en=1, rd_ch < N_CH and the channel's count > 0 before the edge. There is no fall-through: a read of an empty channel with a simultaneous write to that channel is rejected, and the write is still accepted.
- Accepted read: rd_data is loaded with the head word, rd_ch_q = rd_ch, rd_valid = 1 for that one cycle, and rd_ptr increments mod DEPTH.
- Rejected read: rd_valid = 0, rd_data and rd_ch_q hold their values, and udf_err is set.
- Per-channel count: +1 on write only, -1 on read only, unchanged when both or neither. empty = (count==0), full = (count==DEPTH).
- Channel independence: operations on different channels never interact.
- Error flags: err_clr has priority over a new error set in the same cycle.

## Timing
- Write to flags: count, empty and full reflect a write from the edge it is sampled.
- Write to read: a word written at edge k is readable by a request sampled at edge k+1. It appears on rd_data after edge k+1, so minimum write-to-data latency is 2 edges.
- Read latency: 1 cycle from rd_en sampled to rd_data/rd_valid.
- Throughput: back-to-back reads of one channel give one word per cycle.
- Flags are registered outputs. There is no combinational path from inputs to outputs.

## Configuration
- VOQ_ALMOST_FULL_EN defined: adds the AFULL_THRESH parameter and the almost_full port, with almost_full[i] = (count_i >= AFULL_THRESH), registered and reset to 0.
- VOQ_ALMOST_FULL_EN undefined: neither the parameter nor the port exists. All other behaviour is identical.

## Structure
- Shared package switch_pkg: default WIDTH, N_CH and DEPTH constants, and the flit typedef (32-bit payload plus tag bit).
- Sub-module voq_ch_ctrl, instantiated N_CH times via generate:
  - inputs: per-channel push/pop;
  - outputs: wr_ptr, rd_ptr, count, empty, full.
- Top level holds the shared memory of N_CH*DEPTH words, addressed {ch, ptr}, plus the read register and the error logic.

## Test plan
- Reset mid-traffic: fill ch0 with 3 words, assert rst=0 asynchronously between edges -> empty=4'b1111, count=0, rd_valid=0 immediately.
- Per-channel ordering: write 25 to ch0, 78 to ch1, 738 to ch0; read ch0, ch0, ch1 -> rd_data 25, 738, 78 with rd_ch_q 0, 0, 1.
- Full and wrap-around: write DEPTH=8 words 1..8 to ch2 -> full[2]=1; 9th write dropped, ovf_err=1; read 8 -> 1..8 in order; refill 3 -> pointers wrap, data correct.
- Simultaneous read and write: on full ch3, read+write in the same cycle -> both accepted, count stays 8. On empty ch1, read+write -> read rejected, udf_err=1, count becomes 1.
- Error clear: set both errors, pulse err_clr=1 together with a new dropped write -> ovf_err=0, udf_err=0 after the edge.
- VOQ_ALMOST_FULL_EN with AFULL_THRESH=6: 6th write to ch0 -> almost_full[0]=1; one read -> almost_full[0]=0.
